// File: rtl/memory_fifo_pkg.sv
// Shared types and helpers for the memory_fifo block: status-flag bundle and its decode from occupancy.
package memory_fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  // Status flags as a pure function of occupancy and thresholds.
  function automatic fifo_flags_t flags_for_level(input int unsigned lvl,
                                                  input int unsigned depth,
                                                  input int unsigned af_level,
                                                  input int unsigned ae_level);
    fifo_flags_t f;
    f.full         = (lvl == depth);
    f.almost_full  = (lvl >= af_level);
    f.empty        = (lvl == 0);
    f.almost_empty = (lvl <= ae_level);
    return f;
  endfunction

endpackage

// File: rtl/memory_fifo_memory.sv
// Simple dual-port RAM for the FIFO: one clock, write port plus a read port
// that has a read-enable-gated output register and no reset, so it maps onto block RAM.
module fifo_memory #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memory_fifo.sv
// Single-clock FIFO on block RAM: pointers, occupancy counter, threshold
// flags, synchronous flush and sticky overflow/underflow.
module memory_fifo
  import memory_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDR_WIDTH         = 9,
  parameter int unsigned ALMOST_FULL_LEVEL  = (2 ** ADDR_WIDTH) - 4,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
  localparam int unsigned LEVEL_WIDTH = ADDR_WIDTH + 1;

  if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > DEPTH)) begin : g_bad_almost_full
    $error("memory_fifo: ALMOST_FULL_LEVEL out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_LEVEL > (DEPTH - 1)) begin : g_bad_almost_empty
    $error("memory_fifo: ALMOST_EMPTY_LEVEL out of range 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [ADDR_WIDTH-1:0]  wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]  rd_ptr_nxt;
  logic [LEVEL_WIDTH-1:0] level_nxt;
  logic                   push_ok;
  logic                   pop_ok;
  logic                   overflow_nxt;
  logic                   underflow_nxt;
  fifo_flags_t            flags_nxt;

  // Accept/reject decisions use the registered flags, so a full FIFO can
  // never write the slot being read in the same cycle.
  always_comb begin
    push_ok       = write_enable && !full && !flush;
    pop_ok        = read_enable && !empty && !flush;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    level_nxt     = level;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (flush) begin
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      level_nxt     = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else begin
      if (push_ok) wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_nxt = level + LEVEL_WIDTH'(1);
        2'b01:   level_nxt = level - LEVEL_WIDTH'(1);
        default: level_nxt = level;
      endcase
      if (write_enable && full) overflow_nxt  = 1'b1;
      if (read_enable && empty) underflow_nxt = 1'b1;
    end
    flags_nxt = flags_for_level(32'(level_nxt), DEPTH, ALMOST_FULL_LEVEL, ALMOST_EMPTY_LEVEL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      read_valid   <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      full         <= flags_nxt.full;
      almost_full  <= flags_nxt.almost_full;
      empty        <= flags_nxt.empty;
      almost_empty <= flags_nxt.almost_empty;
      read_valid   <= pop_ok;
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

  fifo_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (write_data),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (read_data)
  );

endmodule
